// File: rtl/tds_tx_pkg.sv
// Shared definitions for the TDS transmit framer and its receiver.
// Word headers, control codes, state encoding and word builders.
package tds_tx_pkg;

  localparam logic [1:0]  HDR_DATA  = 2'b01;
  localparam logic [1:0]  HDR_CTRL  = 2'b10;
  localparam logic [1:0]  HDR_EOF   = 2'b11;
  localparam logic [3:0]  SOF_TYPE  = 4'h5;
  localparam logic [19:0] IDLE_WORD = 20'hAAAAA;

  typedef enum logic [2:0] {
    ST_ALIGN,
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } tx_state_e;

  function automatic logic [19:0] sof_word(
    input logic [9:0] fcnt
  );
    return {HDR_CTRL, SOF_TYPE, 4'h0, fcnt};
  endfunction

  function automatic logic [19:0] data_word(
    input logic [17:0] pl
  );
    return {HDR_DATA, pl};
  endfunction

  function automatic logic [19:0] eof_word(
    input logic [17:0] csum
  );
    return {HDR_EOF, csum};
  endfunction

endpackage

// File: rtl/tds_tx_framer.sv
// TDS transmit framer: wraps payload words in SOF/DATA/EOF framing.
// Sends alignment IDLEs after reset or link loss, aborts on link drop.
module tds_tx_framer
  import tds_tx_pkg::*;
#(
  parameter int ALIGN_IDLES = 64,
  parameter int MAX_WORDS   = 16
) (
  input  logic        data_clk,
  input  logic        reset_n,
  input  logic        tx_link_ready,
  input  logic [17:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [19:0] tx_data,
  output logic [9:0]  frame_cnt,
  output logic        frame_done,
  output logic [7:0]  abort_cnt
);

  localparam int AW = $clog2(ALIGN_IDLES + 1);
  localparam int WW = $clog2(MAX_WORDS + 1);

  tx_state_e   state_q, state_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [17:0] csum_q, csum_d;
  logic [19:0] tx_q, tx_d;
  logic [9:0]  fcnt_q, fcnt_d;
  logic [7:0]  abrt_q, abrt_d;
  logic        done_q, done_d;

  assign s_ready    = (state_q == ST_DATA) && tx_link_ready;
  assign tx_data    = tx_q;
  assign frame_cnt  = fcnt_q;
  assign frame_done = done_q;
  assign abort_cnt  = abrt_q;

  // Next state, next output word and counter updates
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    tx_d    = IDLE_WORD;
    fcnt_d  = fcnt_q;
    abrt_d  = abrt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_ALIGN: begin
        if (!tx_link_ready) begin
          acnt_d = '0;
        end else if (acnt_q == AW'(ALIGN_IDLES - 1)) begin
          acnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          acnt_d = acnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (!tx_link_ready) begin
          acnt_d  = '0;
          state_d = ST_ALIGN;
        end else if (s_valid) begin
          state_d = ST_SOF;
        end
      end
      ST_SOF: begin
        if (!tx_link_ready) begin
          acnt_d  = '0;
          state_d = ST_ALIGN;
          abrt_d  = (&abrt_q) ? abrt_q : abrt_q + 8'd1;
        end else begin
          tx_d    = sof_word(fcnt_q);
          csum_d  = '0;
          wcnt_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tx_link_ready) begin
          acnt_d  = '0;
          state_d = ST_ALIGN;
          abrt_d  = (&abrt_q) ? abrt_q : abrt_q + 8'd1;
        end else if (s_valid) begin
          tx_d   = data_word(s_data);
          csum_d = csum_q ^ s_data;
          wcnt_d = wcnt_q + WW'(1);
          if (s_last || wcnt_q == WW'(MAX_WORDS - 1))
            state_d = ST_EOF;
        end
      end
      ST_EOF: begin
        // EOF is already committed here, so a drop still completes it
        tx_d    = eof_word(csum_q);
        done_d  = 1'b1;
        fcnt_d  = fcnt_q + 10'd1;
        acnt_d  = '0;
        state_d = tx_link_ready ? ST_IDLE : ST_ALIGN;
      end
      default: begin
        acnt_d  = '0;
        state_d = ST_ALIGN;
      end
    endcase
  end

  // State, counters and the registered output word
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ALIGN;
      acnt_q  <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
      tx_q    <= IDLE_WORD;
      fcnt_q  <= '0;
      abrt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      tx_q    <= tx_d;
      fcnt_q  <= fcnt_d;
      abrt_q  <= abrt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_tds_tx_framer.sv
// Directed bench for tds_tx_framer with an expected-word queue.
// Covers alignment, framing, MAX_WORDS split, gaps, link drop, reset.
module tb_tds_tx_framer;

  logic        data_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_link_ready = 1'b1;
  logic [17:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [19:0] tx_data;
  logic [9:0]  frame_cnt;
  logic        frame_done;
  logic [7:0]  abort_cnt;

  localparam logic [19:0] IDLE = 20'hAAAAA;

  int          vecs = 0;
  int          miss = 0;
  logic [19:0] exp_q[$];
  logic [9:0]  fc = '0;
  logic [17:0] cs = '0;
  logic [17:0] w[20];

  tds_tx_framer dut (
    .data_clk     (data_clk),
    .reset_n      (reset_n),
    .tx_link_ready(tx_link_ready),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_data      (tx_data),
    .frame_cnt    (frame_cnt),
    .frame_done   (frame_done),
    .abort_cnt    (abort_cnt)
  );

  always #5 data_clk = ~data_clk;

  function automatic logic [19:0] sofw(input logic [9:0] f);
    return {2'b10, 4'h5, 4'h0, f};
  endfunction

  function automatic logic [19:0] dataw(input logic [17:0] d);
    return {2'b01, d};
  endfunction

  function automatic logic [19:0] eofw(input logic [17:0] c);
    return {2'b11, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic l,
                      input logic [17:0] d, input logic lk,
                      input logic [19:0] etx, input logic erdy);
    logic [19:0] e;
    logic        efd;
    s_valid = v;
    s_last = l;
    s_data = d;
    tx_link_ready = lk;
    exp_q.push_back(etx);
    #1;
    chk("s_ready", {31'd0, s_ready}, {31'd0, erdy});
    @(posedge data_clk);
    #1;
    e = exp_q.pop_front();
    efd = (e[19:18] == 2'b11);
    chk("tx_data", {12'd0, tx_data}, {12'd0, e});
    chk("frame_done", {31'd0, frame_done}, {31'd0, efd});
  endtask

  task automatic idle_sof(input logic [17:0] d);
    step(1'b1, 1'b0, d, 1'b1, IDLE, 1'b0);
    step(1'b1, 1'b0, d, 1'b1, sofw(fc), 1'b0);
    cs = '0;
  endtask

  task automatic dat(input logic [17:0] d, input logic l);
    step(1'b1, l, d, 1'b1, dataw(d), 1'b1);
    cs = cs ^ d;
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b1);
  endtask

  task automatic eofs(input logic v, input logic [17:0] d);
    step(v, 1'b0, d, 1'b1, eofw(cs), 1'b0);
    fc = fc + 10'd1;
  endtask

  task automatic wait_sof(input logic [17:0] d);
    int   n;
    logic found;
    n = 0;
    found = 1'b0;
    s_valid = 1'b1;
    s_last = 1'b0;
    s_data = d;
    tx_link_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge data_clk);
      #1;
      if (tx_data !== IDLE) begin
        found = 1'b1;
        break;
      end
      n++;
    end
    chk("sof_after_align", {12'd0, tx_data}, {12'd0, sofw(fc)});
    chk("align_idles", {31'd0, (found && n >= 64 && n <= 70)}, 32'd1);
    cs = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 20; i++) w[i] = 18'($urandom);

    @(posedge data_clk);
    #1;
    chk("rst_tx", {12'd0, tx_data}, {12'd0, IDLE});
    chk("rst_fcnt", {22'd0, frame_cnt}, 32'd0);
    chk("rst_abort", {24'd0, abort_cnt}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_rdy", {31'd0, s_ready}, 32'd0);
    reset_n = 1'b1;

    repeat (70) step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b0);

    chk("fcnt_a0", {22'd0, frame_cnt}, 32'd0);
    idle_sof(18'h00001);
    dat(18'h00001, 1'b0);
    dat(18'h00002, 1'b1);
    eofs(1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b0);
    chk("fcnt_a1", {22'd0, frame_cnt}, {22'd0, fc});

    idle_sof(w[0]);
    for (int i = 0; i < 16; i++) dat(w[i], 1'b0);
    eofs(1'b1, w[16]);
    idle_sof(w[16]);
    for (int i = 16; i < 20; i++) dat(w[i], i == 19);
    eofs(1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b0);
    chk("fcnt_b", {22'd0, frame_cnt}, {22'd0, fc});

    idle_sof(18'h3A5C1);
    dat(18'h3A5C1, 1'b0);
    gap(5);
    dat(18'h0F0F0, 1'b1);
    chk("gap_csum", {14'd0, cs}, {14'd0, 18'h3A5C1 ^ 18'h0F0F0});
    eofs(1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b0);

    idle_sof(w[1]);
    dat(w[1], 1'b0);
    dat(w[2], 1'b0);
    dat(w[3], 1'b0);
    step(1'b1, 1'b0, w[4], 1'b0, IDLE, 1'b0);
    chk("abort_cnt", {24'd0, abort_cnt}, 32'd1);
    chk("fcnt_drop", {22'd0, frame_cnt}, {22'd0, fc});
    repeat (3) step(1'b1, 1'b0, w[4], 1'b0, IDLE, 1'b0);
    wait_sof(w[4]);
    dat(w[4], 1'b1);
    eofs(1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b0);
    chk("fcnt_d", {22'd0, frame_cnt}, {22'd0, fc});

    idle_sof(w[5]);
    dat(w[5], 1'b0);
    dat(w[6], 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_tx", {12'd0, tx_data}, {12'd0, IDLE});
    chk("arst_fcnt", {22'd0, frame_cnt}, 32'd0);
    chk("arst_abort", {24'd0, abort_cnt}, 32'd0);
    chk("arst_done", {31'd0, frame_done}, 32'd0);
    chk("arst_rdy", {31'd0, s_ready}, 32'd0);
    @(posedge data_clk);
    #1;
    chk("arst_hold", {12'd0, tx_data}, {12'd0, IDLE});
    reset_n = 1'b1;
    fc = '0;
    wait_sof(w[7]);
    dat(w[7], 1'b1);
    eofs(1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, IDLE, 1'b0);
    chk("fcnt_e", {22'd0, frame_cnt}, 32'd1);
    chk("abort_e", {24'd0, abort_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/tds_tx_framer.md
TDS_TX_FRAMER -- requirements
Module: tds_tx_framer

Interface
REQ-001 Parameter ALIGN_IDLES, default 64: minimum count of consecutive IDLE words sent after reset or link recovery before the first SOF.
REQ-002 Parameter MAX_WORDS, default 16: maximum number of payload words per frame.
REQ-003 Clocking and reset are decided: one clock; reset is asynchronous and active-low.
REQ-004 data_clk  in  1  transmit user clock (txusrclk2 domain); all logic is on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 tx_link_ready  in  1  transmitter reset FSM done; the link is usable while high.
REQ-007 s_data  in  18  payload word.
REQ-008 s_valid  in  1  s_data is valid.
REQ-009 s_last  in  1  the current word is the last word of its frame.
REQ-010 s_ready  out  1  word accepted when s_valid and s_ready are both high.
REQ-011 tx_data  out  20  registered raw word driven to the GT txdata port.
REQ-012 frame_cnt  out  10  count of completed frames, wraps at 1023->0.
REQ-013 frame_done  out  1  one-cycle pulse, coincident with the cycle EOF appears on tx_data.
REQ-014 abort_cnt  out  8  count of aborted frames, saturates at 255.

Function
REQ-015 Word formats:
- DATA = {2'b01, payload}.
- IDLE = 20'hAAAAA.
- SOF = {2'b10, 4'h5, 4'h0, frame_cnt}.
- EOF = {2'b11, XOR of all payload words in the frame}.
- Header 2'b00 is never emitted.
REQ-016 tx_data is registered: a word decided in cycle n appears in cycle n+1. An accepted payload word appears on tx_data exactly 1 cycle after acceptance.
REQ-017 States are ALIGN, IDLE, SOF, DATA and EOF.
REQ-018 ALIGN:
- Emit IDLE.
- Count cycles while tx_link_ready=1; clear the count while tx_link_ready=0.
- Go to IDLE once the count reaches ALIGN_IDLES.
REQ-019 IDLE: emit IDLE; when s_valid=1, go to SOF.
REQ-020 SOF: emit SOF carrying the current frame_cnt for 1 cycle, clear the checksum and the word counter, then go to DATA.
REQ-021 DATA, s_ready:
- s_ready = (state==DATA) && tx_link_ready.
- s_ready is combinational from registered state and does not depend on s_valid.
REQ-022 DATA, on acceptance: emit DATA, XOR the payload into the checksum and increment the word counter.
REQ-023 DATA, mid-frame gap: when s_valid=0, emit IDLE as filler; the checksum and word counter are unchanged.
REQ-024 DATA, frame end:
- If the accepted word has s_last=1, go to EOF.
- If the word counter reaches MAX_WORDS, go to EOF even when s_last=0; the next word starts a new frame.
REQ-025 EOF:
- Emit EOF and pulse frame_done for 1 cycle.
- Increment frame_cnt.
- Go to IDLE, which guarantees at least 1 IDLE word between frames.
REQ-026 Link drop: if tx_link_ready falls in SOF, DATA or EOF, the next word is IDLE and the state goes to ALIGN.
- No EOF is emitted.
- abort_cnt increments; frame_cnt does not.
- If EOF was already decided in the cycle of the drop, that frame counts as completed, not aborted.
REQ-027 In ALIGN or IDLE, tx_link_ready=0 forces ALIGN and restarts the idle count.
REQ-028 The checksum is 18-bit XOR with no carry. The word counter is wide enough to hold MAX_WORDS.

Reset
REQ-029 While reset_n=0, asynchronously:
- tx_data=20'hAAAAA.
- State = ALIGN; the idle count is 0.
- frame_cnt=0, abort_cnt=0, frame_done=0.
- The checksum is 0; s_ready=0 follows from the state.
REQ-030 Reset asserted mid-frame discards the frame without EOF and does not count it as an abort.
REQ-031 After deassertion, at least ALIGN_IDLES IDLE words precede the first SOF.

Structure
REQ-032 Shared package tds_tx_pkg holds:
- header codes (DATA, CTRL, EOF);
- SOF type nibble 4'h5;
- IDLE_WORD 20'hAAAAA;
- the state enumeration.
REQ-033 Single module, no sub-module; the matching receiver/checker imports the same package.

Verification
REQ-034 Reset with tx_link_ready=1 and s_valid=0 -> tx_data=20'hAAAAA every cycle; s_ready=0 for the first 64 cycles; no SOF is ever emitted.
REQ-035 After alignment, two words 18'h00001 and 18'h00002 (s_last on the second) -> tx_data sequence 20'h94000, 20'h40001, 20'h40002, 20'hC0003, 20'hAAAAA; frame_done pulses once; frame_cnt goes 0->1.
REQ-036 Continuous 20-word burst with s_last only on word 20 ->
- SOF(0), 16 DATA, EOF, IDLE;
- then SOF carrying frame_cnt=1 (20'h94001), 4 DATA, EOF;
- frame_cnt=2.
REQ-037 Link drop after 3 accepted words ->
- the next tx_data is 20'hAAAAA with no EOF;
- abort_cnt=1, frame_cnt unchanged;
- after the link returns, 64 IDLEs precede the next SOF.
REQ-038 s_valid low for 5 cycles between words 1 and 2 of a 2-word frame -> 5 IDLE words appear between the two DATA words, and the EOF checksum equals word1 XOR word2.
REQ-039 reset_n asserted during DATA -> tx_data=20'hAAAAA in the same cycle, all counters are 0, and no EOF is emitted.
